// File: rtl/jpeg_stream_player.sv
// rtl/jpeg_stream_player.sv - JPEG byte-stream player with stall watchdog and pixel-count monitor
//
// Plays a byte image held in on-chip memory into the JPEG parser over a
// valid/ready byte stream, then counts decoder output pixels until the
// output has been quiet for DRAIN cycles and flags a count mismatch.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load_we/load_addr/load_data   image memory write port (dropped while busy)
//   len, gap, exp_pixels          run parameters, latched on start
//   start                         begin a run (accepted in IDLE, DONE, ERR)
//   byte_out/byte_valid/byte_ready  stream to the parser
//   pix_valid                     decoder rgb_valid
//   busy, done, deadlock          run status
//   pix_mismatch                  pixel count differs from exp_pixels (valid with done)
//   bytes_sent, pix_count         progress counters
module jpeg_stream_player #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int GAP_W   = 4,
    parameter int PIX_W   = 24,
    parameter int TIMEOUT = 2000,
    parameter int DRAIN   = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   len,
    input  logic [GAP_W-1:0]  gap,
    input  logic [PIX_W-1:0]  exp_pixels,
    input  logic              start,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    input  logic              pix_valid,
    output logic              busy,
    output logic              done,
    output logic              deadlock,
    output logic              pix_mismatch,
    output logic [ADDR_W:0]   bytes_sent,
    output logic [PIX_W-1:0]  pix_count
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_GAP, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     len_q;
    logic [GAP_W-1:0]    gap_q;
    logic [GAP_W-1:0]    gap_cnt;
    logic [PIX_W-1:0]    exp_q;
    logic [SW-1:0]       stall_cnt;
    logic [DW-1:0]       drain_cnt;
    logic                last_byte;
    logic                counting;

    assign last_byte = (bytes_sent + (ADDR_W+1)'(1)) == len_q;
    assign counting  = (state == S_FETCH) || (state == S_SEND) ||
                       (state == S_GAP)   || (state == S_DRAIN);

    // Image memory is deliberately outside reset so a run can be replayed.
    always_ff @(posedge clk) begin
        if (load_we && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    // byte_out doubles as the registered memory read port: it is loaded in
    // FETCH and prefetched with the following byte on every transfer, so it
    // already holds the next byte when SEND resumes after a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            len_q        <= '0;
            gap_q        <= '0;
            gap_cnt      <= '0;
            exp_q        <= '0;
            stall_cnt    <= '0;
            drain_cnt    <= '0;
            byte_out     <= '0;
            byte_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            deadlock     <= 1'b0;
            pix_mismatch <= 1'b0;
            bytes_sent   <= '0;
            pix_count    <= '0;
        end else begin
            if (counting && pix_valid && (pix_count != '1)) begin
                pix_count <= pix_count + PIX_W'(1);
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        len_q        <= len;
                        gap_q        <= gap;
                        exp_q        <= exp_pixels;
                        ptr          <= '0;
                        bytes_sent   <= '0;
                        pix_count    <= '0;
                        stall_cnt    <= '0;
                        drain_cnt    <= '0;
                        done         <= 1'b0;
                        deadlock     <= 1'b0;
                        pix_mismatch <= 1'b0;
                        busy         <= 1'b1;
                        state        <= (len != '0) ? S_FETCH : S_DRAIN;
                    end
                end

                S_FETCH: begin
                    byte_out   <= mem[ptr];
                    byte_valid <= 1'b1;
                    state      <= S_SEND;
                end

                S_SEND: begin
                    if (byte_ready) begin
                        bytes_sent <= bytes_sent + (ADDR_W+1)'(1);
                        stall_cnt  <= '0;
                        ptr        <= ptr + ADDR_W'(1);
                        if (last_byte) begin
                            byte_valid <= 1'b0;
                            state      <= S_DRAIN;
                        end else begin
                            byte_out <= mem[ptr + ADDR_W'(1)];
                            if (gap_q != '0) begin
                                byte_valid <= 1'b0;
                                gap_cnt    <= gap_q;
                                state      <= S_GAP;
                            end
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        byte_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        deadlock   <= 1'b1;
                        state      <= S_ERR;
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        byte_valid <= 1'b1;
                        state      <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (pix_valid) begin
                        drain_cnt <= '0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        pix_mismatch <= (pix_count != exp_q);
                        state        <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_stream_player.sv
// tb/tb_jpeg_stream_player.sv - self-checking bench for jpeg_stream_player
module tb_jpeg_stream_player;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int GAP_W   = 4;
    localparam int PIX_W   = 24;
    localparam int TIMEOUT = 16;
    localparam int DRAIN   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_we = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [DATA_W-1:0] load_data = '0;
    logic [ADDR_W:0]   len_i = '0;
    logic [GAP_W-1:0]  gap_i = '0;
    logic [PIX_W-1:0]  exp_i = '0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready = 1'b1;
    logic              pix_valid = 1'b0;
    logic              busy, done, deadlock, pix_mismatch;
    logic [ADDR_W:0]   bytes_sent;
    logic [PIX_W-1:0]  pix_count;

    jpeg_stream_player #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAP_W(GAP_W), .PIX_W(PIX_W),
        .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)
    ) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .len(len_i), .gap(gap_i), .exp_pixels(exp_i), .start(start),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .pix_valid(pix_valid), .busy(busy), .done(done), .deadlock(deadlock),
        .pix_mismatch(pix_mismatch), .bytes_sent(bytes_sent), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Stream model: expected byte order, expected idle cycles between
    // transfers, and stability of presented data under backpressure.
    logic [7:0] exp_bytes[$];
    int         xfer_cyc[$];
    int         exp_gap, gap_run, exp_sent, bb_cycles;
    int         cyc = 0;
    bit         seen_first, last_stall;
    logic [7:0] last_byte;
    logic [7:0] vals [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) begin
                if (byte_out == 8'hBB) bb_cycles++;
                if (last_stall) check("mon_hold_stable", byte_out, last_byte);
                if (byte_ready) begin
                    check("mon_xfer_expected", exp_bytes.size() != 0, 1);
                    if (exp_bytes.size() != 0) check("mon_byte", byte_out, exp_bytes.pop_front());
                    check("mon_bytes_sent", bytes_sent, exp_sent);
                    exp_sent++;
                    if (seen_first) check("mon_gap", gap_run, exp_gap);
                    seen_first = 1;
                    gap_run = 0;
                    xfer_cyc.push_back(cyc);
                end
                last_stall = !byte_ready;
                last_byte  = byte_out;
            end else begin
                if (seen_first) gap_run++;
                last_stall = 0;
            end
        end
    end

    task automatic mon_reset(input int g);
        exp_bytes.delete();
        xfer_cyc.delete();
        exp_gap = g; gap_run = 0; exp_sent = 0; bb_cycles = 0;
        seen_first = 0; last_stall = 0;
    endtask

    task automatic push_bytes(input int n);
        for (int i = 0; i < n; i++) exp_bytes.push_back(vals[i]);
    endtask

    task automatic start_run(input int l, input int g, input int e);
        @(posedge clk); #1;
        len_i = (ADDR_W+1)'(l); gap_i = GAP_W'(g); exp_i = PIX_W'(e); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, done, 1);
    endtask

    task automatic check_zero(input string name);
        check(name, {byte_out, byte_valid, busy, done, deadlock, pix_mismatch, bytes_sent, pix_count}, 0);
    endtask

    // n pulses, spaced 2..9 cycles apart; ends in the cycle after the last pulse.
    task automatic pix_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0) repeat (i % 8) @(posedge clk);
            @(posedge clk); #1; pix_valid = 1'b1;
            @(posedge clk); #1; pix_valid = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        mon_reset(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset_outputs");

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            load_we = 1'b1; load_addr = ADDR_W'(i); load_data = vals[i];
        end
        @(posedge clk); #1 load_we = 1'b0;

        // Four bytes back to back.
        mon_reset(0); push_bytes(4);
        start_run(4, 0, 0);
        @(negedge clk);
        check("t1_fetch_no_valid", byte_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", byte_valid, 1);
            check("t1_byte", byte_out, vals[i]);
        end
        @(negedge clk);
        check("t1_valid_low_after", byte_valid, 0);
        check("t1_bytes_sent", bytes_sent, 4);
        wait_done(100, "t1_done");
        check("t1_mismatch", pix_mismatch, 0);
        check("t1_deadlock", deadlock, 0);
        check("t1_all_sent", exp_bytes.size(), 0);

        // Backpressure on BB for 5 cycles.
        mon_reset(0); push_bytes(4);
        start_run(4, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 byte_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 byte_ready = 1'b1;
        wait_done(100, "t2_done");
        check("t2_bb_held_cycles", bb_cycles, 6);
        check("t2_bytes_sent", bytes_sent, 4);
        check("t2_deadlock", deadlock, 0);
        check("t2_all_sent", exp_bytes.size(), 0);

        // gap=3, plus a start and a memory write while busy, both to be ignored.
        mon_reset(3); push_bytes(3);
        start_run(3, 3, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; load_we = 1'b1; load_addr = ADDR_W'(1); load_data = 8'h55;
        @(posedge clk); #1;
        start = 1'b0; load_we = 1'b0;
        wait_done(100, "t3_done");
        check("t3_xfers", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            check("t3_spacing_1", xfer_cyc[1] - xfer_cyc[0], 4);
            check("t3_spacing_2", xfer_cyc[2] - xfer_cyc[1], 4);
        end
        check("t3_all_sent", exp_bytes.size(), 0);

        // Watchdog with byte_ready stuck low.
        mon_reset(0); push_bytes(4);
        byte_ready = 1'b0;
        start_run(4, 0, 0);
        repeat (17) @(negedge clk);
        check("t4_deadlock_not_yet", deadlock, 0);
        check("t4_still_valid", byte_valid, 1);
        @(negedge clk);
        check("t4_deadlock", deadlock, 1);
        check("t4_done", done, 1);
        check("t4_valid_low", byte_valid, 0);
        check("t4_bytes_sent", bytes_sent, 0);
        check("t4_mismatch", pix_mismatch, 0);
        check("t4_busy", busy, 0);
        byte_ready = 1'b1;

        // 64 pixels expected 64, no bytes; done exactly DRAIN+1 after the last pulse.
        mon_reset(0);
        start_run(0, 0, 64);
        pix_pulses(64);
        repeat (DRAIN) @(negedge clk);
        check("t5_done_not_yet", done, 0);
        @(negedge clk);
        check("t5_done", done, 1);
        check("t5_pix_count", pix_count, 64);
        check("t5_mismatch", pix_mismatch, 0);

        // 63 pixels against 64 expected, counted while bytes stream.
        mon_reset(0); push_bytes(4);
        start_run(4, 0, 64);
        pix_pulses(63);
        wait_done(100, "t5b_done");
        check("t5b_pix_count", pix_count, 63);
        check("t5b_mismatch", pix_mismatch, 1);
        check("t5b_bytes_sent", bytes_sent, 4);

        // Reset during byte 2, then replay without reloading.
        mon_reset(0); push_bytes(4);
        start_run(4, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_zero("t6_reset_outputs");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_no_more_bytes", {byte_valid, busy}, 0);
        end
        mon_reset(0); push_bytes(4);
        start_run(4, 0, 0);
        wait_done(100, "t6_done");
        check("t6_bytes_sent", bytes_sent, 4);
        check("t6_replayed", exp_bytes.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jpeg_stream_player.md
# jpeg_stream_player

Synthesizable stimulus-and-monitor engine for the JPEG decoder bring-up path. It holds a compressed JPEG byte image in on-chip memory and streams it into `jpeg_decoder_top` over a valid/ready byte interface with a programmable inter-byte gap. A stall watchdog flags deadlock. After the last byte it counts decoder `rgb_valid` pixels until the output goes quiet, then reports pass/fail against an expected pixel count. It replaces bench-only feeding so that the same stream test runs in simulation and on FPGA.

## Interface
- `DATA_W`, 8: stream byte width.
- `ADDR_W`, 16: memory address width; depth is 2^ADDR_W entries.
- `GAP_W`, 4: width of the `gap` input.
- `PIX_W`, 24: width of the pixel counter and of `exp_pixels`.
- `TIMEOUT`, 2000: consecutive stalled cycles that trigger deadlock.
- `DRAIN`, 2500: consecutive cycles with no `pix_valid` that end the run.

Ports:
- `clk`, in, 1: single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `load_we`, in, 1: memory write strobe. Ignored while `busy`.
- `load_addr`, in, ADDR_W: memory write address.
- `load_data`, in, DATA_W: memory write data.
- `len`, in, ADDR_W+1: number of bytes to play (0 to 2^ADDR_W). Sampled on start.
- `gap`, in, GAP_W: idle cycles inserted after each transfer. Sampled on start.
- `exp_pixels`, in, PIX_W: expected pixel count. Sampled on start.
- `start`, in, 1: begin a run. Accepted only in IDLE, DONE or ERR.
- `byte_out`, out, DATA_W: stream data to the parser.
- `byte_valid`, out, 1: stream valid.
- `byte_ready`, in, 1: connected to parser_ready.
- `pix_valid`, in, 1: connected to decoder rgb_valid.
- `busy`, out, 1: high in FETCH, SEND, GAP and DRAIN.
- `done`, out, 1: run finished, either DONE or ERR.
- `deadlock`, out, 1: watchdog fired.
- `pix_mismatch`, out, 1: `pix_count` != latched `exp_pixels`. Valid only while `done`=1.
- `bytes_sent`, out, ADDR_W+1: number of completed transfers.
- `pix_count`, out, PIX_W: `pix_valid` cycles counted during the run. Saturates at all-ones.

## Operation
- Memory: DATA_W × 2^ADDR_W, one write port and one registered read port (1-cycle read latency).
  - Memory contents are not affected by `rst`.
- FSM states: IDLE, FETCH, SEND, GAP, DRAIN, DONE, ERR.
- IDLE/DONE/ERR on `start`:
  - Latch `len`, `gap` and `exp_pixels`.
  - Clear `bytes_sent`, `pix_count`, the stall counter, the drain counter, `done`, `deadlock` and `pix_mismatch`.
  - Go to FETCH if `len`≠0, otherwise go to DRAIN.
- FETCH: issue a read at pointer 0, then go to SEND.
- SEND: `byte_valid`=1 and `byte_out`=mem[ptr].
  - A transfer occurs on a cycle where `byte_valid` && `byte_ready`. Each transfer increments `bytes_sent` and `ptr`.
  - After a transfer:
    - If it was the last byte, go to DRAIN.
    - Else if latched `gap`>0, go to GAP.
    - Else stay in SEND with the next byte presented on the following cycle. The next read is prefetched so that gap=0 sustains 1 byte per cycle.
  - While stalled (`byte_valid`=1, `byte_ready`=0), `byte_out` holds stable and the stall counter increments.
  - Any transfer clears the stall counter.
  - When the stall counter reaches TIMEOUT, go to ERR.
- GAP: `byte_valid`=0 for exactly the latched `gap` cycles, then go to SEND.
- DRAIN: `byte_valid`=0.
  - The drain counter increments on each cycle with `pix_valid`=0 and clears on `pix_valid`=1.
  - When the drain counter reaches DRAIN, go to DONE.
- DONE: `done`=1, and `pix_mismatch` is the registered compare result. Hold until `start`.
- ERR: `byte_valid`=0, `deadlock`=1, `done`=1, `pix_mismatch`=0. Hold until `start` or `rst`.
- Pixel counting: `pix_valid` is counted in FETCH, SEND, GAP and DRAIN only. It is ignored in IDLE, DONE and ERR.
- Simultaneous events:
  - `start` while `busy` is ignored.
  - `load_we` while `busy` is dropped and memory is unchanged.
  - A transfer on the same cycle as stall-count==TIMEOUT−1 counts as a transfer; no deadlock is raised.

## Timing
- Reset: every output is 0 on the cycle after `rst` is sampled high; state returns to IDLE. Reset mid-run aborts the run with no further bytes sent.
- Start latency: `start` sampled at edge N puts the FSM in FETCH in cycle N+1; `byte_valid` first rises in cycle N+2.
- gap=0 with `byte_ready` held at 1: `len` bytes transfer on `len` consecutive cycles.
- gap=G: exactly G cycles with `byte_valid`=0 between consecutive transfers.
- Deadlock: `deadlock` rises on the cycle after TIMEOUT consecutive stalled cycles.
- Completion: `done` rises DRAIN+1 cycles after the last `pix_valid` (or after the last transfer, if no pixel follows it).

## Test plan
- Feed four bytes: load AA,BB,CC,DD; `len`=4, `gap`=0, `byte_ready`=1. Expect AA..DD on cycles N+2..N+5 and `bytes_sent`=4.
- Backpressure: same load, with `byte_ready`=0 for 5 cycles while BB is presented. Expect BB held for 6 cycles, no duplicate or lost byte, and `deadlock`=0.
- Gap timing: `gap`=3, `len`=3. Expect exactly 3 low-valid cycles between each transfer.
- Watchdog: TIMEOUT=16, `byte_ready` stuck at 0. Expect `deadlock`=1 and `done`=1 on the 17th stalled cycle, `byte_valid`=0, and `bytes_sent`=0.
- Pixel pass/fail: DRAIN=32, `exp_pixels`=64, with 64 `pix_valid` pulses spaced ≤10 cycles apart. Expect `done`=1 and `pix_mismatch`=0. Repeat with 63 pulses and expect `pix_mismatch`=1.
- Reset mid-run: assert `rst` during byte 2 of 4. Expect all outputs 0 on the next cycle. A new `start` with no reload replays AA..DD from address 0.
